// File: rtl/perf_counter_bank.sv
// perf_counter_bank: NUM_CH event counters (wrap/saturate, sticky overflow) with atomic snapshot and a button-stepped readout selector.
// Define PERF_DELTA_EN to add a previous-snapshot bank and the delta_data output.
module perf_counter_bank #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 32,
    parameter int SEL_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NUM_CH-1:0]    events,
    input  logic                 clr,
    input  logic                 sat_mode,
    input  logic                 snap,
    input  logic                 change,
    output logic [SEL_WIDTH-1:0] sel,
    output logic [CNT_WIDTH-1:0] rd_data,
`ifdef PERF_DELTA_EN
    output logic [CNT_WIDTH-1:0] delta_data,
`endif
    output logic [NUM_CH-1:0]    ovf
);
    logic [CNT_WIDTH-1:0] cnt      [NUM_CH];
    logic [CNT_WIDTH-1:0] snapshot [NUM_CH];
    logic                 change_q;

    // clr wins over any increment; an all-ones counter flags overflow and either wraps or holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
            ovf <= '0;
        end else if (clr) begin
            for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
            ovf <= '0;
        end else if (en) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (events[k]) begin
                    if (&cnt[k]) begin
                        ovf[k] <= 1'b1;
                        cnt[k] <= sat_mode ? cnt[k] : '0;
                    end else begin
                        cnt[k] <= cnt[k] + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) snapshot[k] <= '0;
        end else if (snap) begin
            for (int k = 0; k < NUM_CH; k++) snapshot[k] <= cnt[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            change_q <= 1'b0;
            sel      <= '0;
        end else begin
            change_q <= change;
            if (change && !change_q)
                sel <= (sel == SEL_WIDTH'(NUM_CH - 1)) ? '0 : sel + SEL_WIDTH'(1);
        end
    end

    assign rd_data = snapshot[sel];

`ifdef PERF_DELTA_EN
    logic [CNT_WIDTH-1:0] prev_snapshot [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) prev_snapshot[k] <= '0;
        end else if (snap) begin
            for (int k = 0; k < NUM_CH; k++) prev_snapshot[k] <= snapshot[k];
        end
    end

    assign delta_data = snapshot[sel] - prev_snapshot[sel];
`endif
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: scoreboard bench; a 4-channel and a 3-channel 4-bit instance share one stimulus stream.
module tb_perf_counter_bank;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] events = '0;
    logic       clr = 1'b0;
    logic       sat_mode = 1'b0;
    logic       snap = 1'b0;
    logic       change = 1'b0;
    logic [1:0] sel_a, sel_b;
    logic [3:0] rd_a, rd_b;
    logic [3:0] ovf_a;
    logic [2:0] ovf_b;
`ifdef PERF_DELTA_EN
    logic [3:0] delta_a, delta_b;
`endif

    typedef struct {
        string name;
        int    kind;
        int    exp;
    } item_t;

    item_t q[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_CH(4), .CNT_WIDTH(4), .SEL_WIDTH(2)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .events(events), .clr(clr),
        .sat_mode(sat_mode), .snap(snap), .change(change),
        .sel(sel_a), .rd_data(rd_a),
`ifdef PERF_DELTA_EN
        .delta_data(delta_a),
`endif
        .ovf(ovf_a)
    );

    perf_counter_bank #(.NUM_CH(3), .CNT_WIDTH(4), .SEL_WIDTH(2)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .events(events[2:0]), .clr(clr),
        .sat_mode(sat_mode), .snap(snap), .change(change),
        .sel(sel_b), .rd_data(rd_b),
`ifdef PERF_DELTA_EN
        .delta_data(delta_b),
`endif
        .ovf(ovf_b)
    );

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            0: observe = 32'(sel_a);
            1: observe = 32'(rd_a);
            2: observe = 32'(ovf_a);
            3: observe = 32'(sel_b);
            4: observe = 32'(rd_b);
            5: observe = 32'(ovf_b);
`ifdef PERF_DELTA_EN
            6: observe = 32'(delta_a);
`endif
            default: observe = 'x;
        endcase
    endfunction

    // monitor: every expectation queued before a falling edge is checked at that edge
    always @(negedge clk) begin
        while (q.size() > 0) begin
            item_t it;
            logic [31:0] act;
            it = q.pop_front();
            act = observe(it.kind);
            checks++;
            if (act !== 32'(it.exp)) begin
                failures++;
                $display("FAIL %s: got %0d expected %0d", it.name, act, it.exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string name, input int kind, input int exp);
        item_t it;
        it.name = name;
        it.kind = kind;
        it.exp = exp;
        q.push_back(it);
    endtask

    task automatic pulse_change(input int len);
        change = 1'b1;
        tick(len);
        change = 1'b0;
    endtask

    task automatic do_snap();
        snap = 1'b1;
        tick(1);
        snap = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(10);
        expect_val("reset_sel_a", 0, 0);
        expect_val("reset_rd_a", 1, 0);
        expect_val("reset_ovf_a", 2, 0);
        expect_val("reset_sel_b", 3, 0);
        expect_val("reset_rd_b", 4, 0);

        // count 5 on ch0/ch2, then freeze with events still asserted
        en = 1'b1;
        events = 4'b0101;
        tick(5);
        en = 1'b0;
        tick(3);
        events = 4'b0000;
        do_snap();
        expect_val("count_ch0", 1, 5);
        pulse_change(1);
        expect_val("sel_step1", 0, 1);
        expect_val("count_ch1", 1, 0);
        tick(1);
        pulse_change(1);
        expect_val("sel_step2", 0, 2);
        expect_val("count_ch2", 1, 5);
        expect_val("count_ch2_b", 4, 5);
        tick(1);

        // held change advances once; b wraps 2->0
        do_clr();
        pulse_change(5);
        expect_val("held_sel_a", 0, 3);
        expect_val("held_wrap_sel_b", 3, 0);
        tick(1);
        pulse_change(1);
        expect_val("wrap_sel_a", 0, 0);
        expect_val("wrap_sel_b", 3, 1);
        tick(1);

        // 17 events on ch0: wrap mode then saturate mode
        en = 1'b1;
        events = 4'b0001;
        tick(17);
        events = 4'b0000;
        do_snap();
        expect_val("wrap_cnt", 1, 1);
        expect_val("wrap_ovf_a", 2, 1);
        expect_val("wrap_ovf_b", 5, 1);
        do_clr();
        expect_val("clr_ovf", 2, 0);
        sat_mode = 1'b1;
        events = 4'b0001;
        tick(17);
        events = 4'b0000;
        do_snap();
        expect_val("sat_cnt", 1, 15);
        expect_val("sat_ovf", 2, 1);

        // clr and snap together with an increment pending on ch1
        do_clr();
        sat_mode = 1'b0;
        events = 4'b0010;
        tick(7);
        clr = 1'b1;
        snap = 1'b1;
        tick(1);
        clr = 1'b0;
        snap = 1'b0;
        events = 4'b0000;
        expect_val("clrsnap_ovf", 2, 0);
        expect_val("clrsnap_b_ch1", 4, 7);
        pulse_change(1);
        expect_val("clrsnap_sel", 0, 1);
        expect_val("clrsnap_snap", 1, 7);
        tick(1);
        do_snap();
        expect_val("clrsnap_cnt", 1, 0);

`ifdef PERF_DELTA_EN
        do_clr();
        events = 4'b0010;
        tick(4);
        events = 4'b0000;
        do_snap();
        events = 4'b0010;
        tick(6);
        events = 4'b0000;
        do_snap();
        expect_val("delta_rd", 1, 10);
        expect_val("delta_6", 6, 6);
        do_clr();
        events = 4'b0010;
        tick(14);
        events = 4'b0000;
        do_snap();
        events = 4'b0010;
        tick(5);
        events = 4'b0000;
        do_snap();
        expect_val("delta_wrap_rd", 1, 3);
        expect_val("delta_wrap", 6, 5);
`endif

        // async reset mid-count must act before the next rising edge
        do_clr();
        events = 4'b1111;
        tick(3);
        events = 4'b0000;
        do_snap();
        expect_val("pre_rst_rd", 1, 3);
        tick(1);
        rst_n = 1'b0;
        expect_val("async_sel_a", 0, 0);
        expect_val("async_rd_a", 1, 0);
        expect_val("async_sel_b", 3, 0);
        tick(2);
        rst_n = 1'b1;
        events = 4'b0001;
        tick(2);
        events = 4'b0000;
        do_snap();
        expect_val("resume_cnt", 1, 2);

        tick(2);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised successor to the single-purpose cycle-statistics counter. It provides NUM_CH independent event counters with configurable width. Each counter has per-bank wrap or saturate mode and sticky overflow flags. All counters can be captured atomically into snapshot registers, and a button-driven channel selector drives the seven-segment display path. The block sits beside the CPU datapath: it takes pcen-style gating and per-event strobes (taken branch, untaken branch, jump, syscall, ...), and its rd_data feeds the display driver.

Parameters:
NUM_CH, 4, number of counter channels (2..16)
CNT_WIDTH, 32, width of each counter and snapshot register (4..32)
SEL_WIDTH, 2, width of channel selector; must satisfy 2^SEL_WIDTH >= NUM_CH

Ports:
clk  input  1  system clock (CPU clock domain, clk_N in top level)
rst_n  input  1  asynchronous active-low reset
en  input  1  global count enable; 0 freezes all counters (CPU halted)
event  input  NUM_CH  per-channel increment strobe, sampled at rising clk
clr  input  1  synchronous clear of counters and overflow flags
sat_mode  input  1  0 = wrap on overflow, 1 = saturate at all-ones
snap  input  1  capture all counters into snapshot registers
change  input  1  level input (debounced button); rising edge advances selector
sel  output  SEL_WIDTH  currently selected channel
rd_data  output  CNT_WIDTH  snapshot value of channel sel (combinational from registers)
ovf  output  NUM_CH  sticky overflow flag per channel

Behaviour:
- Reset (rst_n=0, async): all counters, snapshots, ovf, sel and the change-edge register are cleared to 0, so rd_data=0.
- Increment: at a rising clk edge, counter[k] increments by 1 iff en=1 and event[k]=1. Channels are independent, and any subset may increment in the same cycle. Latency is 1 cycle, with no pipelining.
- Overflow, wrap mode (sat_mode=0): all-ones+1 becomes 0 and ovf[k] is set.
- Overflow, saturate mode (sat_mode=1): the counter holds at all-ones and ovf[k] is set on the first attempted increment past all-ones. Further increments keep it held.
- ovf[k] is sticky. Only clr or reset clears it. sat_mode may change at any time and takes effect at the next edge.
- clr priority: clr=1 forces counters and ovf to 0 and overrides any increment in that cycle. Snapshots and sel are unaffected.
- Snapshot: snap=1 loads snapshot[k] with the current register value of counter[k] for all k simultaneously. This is the value before that edge's increment or clear.
  - snap and clr in the same cycle: the snapshot gets the pre-clear values.
  - snap is ignored only during reset.
- Selector:
  - change_q registers change every cycle.
  - On change=1 and change_q=0, sel advances: sel == NUM_CH-1 wraps to 0, otherwise sel+1.
  - Holding change high yields exactly one advance.
  - sel never takes a value >= NUM_CH.
- rd_data = snapshot[sel]. It updates in the cycle after snap or after a sel change.
- Reset mid-count: async, takes effect immediately without waiting for clk. On release, counting resumes from 0 at the first edge with en=1.
- The en=0 freeze does not block clr, snap or selector movement.

Optional Feature:
PERF_DELTA_EN:
- Defined:
  - Adds an output delta_data [CNT_WIDTH] and a second register bank prev_snapshot.
  - On snap, prev_snapshot[k] <= snapshot[k] while snapshot[k] <= counter[k].
  - delta_data = snapshot[sel] - prev_snapshot[sel], modulo 2^CNT_WIDTH.
  - Reset clears prev_snapshot. clr does not touch it.
- Undefined: no delta_data port and no prev_snapshot registers. Behaviour is otherwise identical.

Test Plan:
- Reset/idle: hold rst_n=0, then release with all inputs 0 for 10 cycles -> sel=0, rd_data=0, ovf=0.
- Counting and gating: event=4'b0101 for 5 cycles with en=1, then 3 cycles with en=0, then snap -> snapshot ch0=5, ch1=0, ch2=5, ch3=0. Select ch2 with one change pulse after two more pulses -> sel sequence 1,2; rd_data=5 at sel=2.
- Overflow (CNT_WIDTH=4): ch0 gets 17 events with sat_mode=0 -> counter=1, ovf[0]=1. Repeat after clr with sat_mode=1 -> counter=15, ovf[0]=1.
- Clear vs increment vs snap: with counter ch1=7 and event[1]=1, assert clr and snap together -> snapshot ch1=7, counter ch1=0, ovf=0.
- Selector wrap: NUM_CH=3, apply 4 change pulses, with one pulse held high 5 cycles -> sel 1,2,0,1; the held pulse advances once.
- PERF_DELTA_EN: snap at count 10, count 6 more, snap again -> delta_data=6. Wrap case (CNT_WIDTH=4) from 14 to 3 -> delta_data=5.
